// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: multdiv start/wait,
// load-use interlock, taken-branch flush and a saturating stall counter.
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_inst,
  input  logic [31:0] dx_inst,
  input  logic        branch_taken,
  input  logic        multdiv_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        multdiv_start,
  output logic        md_timeout,
  output logic [31:0] stall_count,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_timeout_q, md_timeout_d;
  logic [31:0]   stall_count_q, stall_count_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       dx_muldiv, dx_load, load_use, start_raw;

  // Low bits of both instructions and the D/X source fields play no part here.
  logic unused_bits;
  assign unused_bits = ^{fd_inst[11:0], dx_inst[21:7], dx_inst[1:0]};

  always_comb begin
    fd_op    = fd_inst[31:27];
    fd_rd    = fd_inst[26:22];
    fd_rs    = fd_inst[21:17];
    fd_rt    = fd_inst[16:12];
    dx_op    = dx_inst[31:27];
    dx_rd    = dx_inst[26:22];
    dx_aluop = dx_inst[6:2];

    dx_muldiv = (dx_op == 5'b00000) && (dx_aluop == 5'b00110 || dx_aluop == 5'b00111);
    dx_load   = (dx_op == 5'b01000) && (dx_rd != 5'd0);

    // dx_load already excludes r0, so a zero source can never match.
    load_use = 1'b0;
    if (dx_load) begin
      if ((fd_op == 5'b00000 || fd_op == 5'b00101 || fd_op == 5'b01000 ||
           fd_op == 5'b00111 || fd_op == 5'b00010 || fd_op == 5'b00110) && fd_rs == dx_rd)
        load_use = 1'b1;
      if (fd_op == 5'b00000 && fd_rt == dx_rd)
        load_use = 1'b1;
      if ((fd_op == 5'b00111 || fd_op == 5'b00010 || fd_op == 5'b00110 ||
           fd_op == 5'b00100) && fd_rd == dx_rd)
        load_use = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_timeout_d = 1'b0;
    start_raw    = 1'b0;
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    xm_bubble    = 1'b0;

    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (multdiv_ready) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_DONE;
          md_timeout_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (dx_muldiv) begin
          start_raw = 1'b1;
          state_d   = S_BUSY;
          cnt_d     = '0;
        end
      end
    endcase

    // Branch outranks load-use; the X-stage redirect squashes both younger stages.
    if (state_q == S_BUSY || start_raw) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_bubble = 1'b1;
    end else if (branch_taken) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_flush = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!pc_en && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      md_timeout_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      md_timeout_q  <= md_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign multdiv_start = start_raw & reset;
  assign md_timeout    = md_timeout_q;
  assign stall_count   = stall_count_q;
  assign state_dbg     = state_q;

endmodule
